gpr_wb_arbiter: RTL and testbench

Write-back arbiter and scoreboard for the 32-entry GPR. Up to NREQ write-back sources (ALU, LSU, CSR, …) compete for the GPR's single write port. The block grants one source per cycle, round-robin, and registers the winner onto the GPR write port. It also keeps a per-register busy scoreboard so decode can stall on pending writes (RAW) and refuse a second outstanding write to the same register (WAW).

---
 rtl/gpr_wb_arbiter_if.sv | 34 +++
 rtl/gpr_wb_arbiter.sv | 80 ++++++++
 tb/tb_gpr_wb_arbiter.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/gpr_wb_arbiter_if.sv
// Bundle of write-back request, issue/scoreboard and GPR write-port signals
// shared between the GPR write-back arbiter and its surroundings.
interface gpr_wb_arbiter_if #(
  parameter int DATA_WIDTH = 64,
  parameter int NREQ       = 3
);
  logic [NREQ-1:0]            req_valid;
  logic [5*NREQ-1:0]          req_addr;
  logic [DATA_WIDTH*NREQ-1:0] req_data;
  logic [NREQ-1:0]            req_ready;
  logic                       iss_valid;
  logic [4:0]                 iss_rd;
  logic                       iss_ready;
  logic [4:0]                 rs1_addr;
  logic [4:0]                 rs2_addr;
  logic                       rs1_busy;
  logic                       rs2_busy;
  logic                       gpr_wen;
  logic [4:0]                 gpr_waddr;
  logic [DATA_WIDTH-1:0]      gpr_wdata;
  logic [31:0]                busy_vec;

  modport master (
    output req_valid, req_addr, req_data, iss_valid, iss_rd, rs1_addr, rs2_addr,
    input  req_ready, iss_ready, rs1_busy, rs2_busy,
           gpr_wen, gpr_waddr, gpr_wdata, busy_vec
  );

  modport slave (
    input  req_valid, req_addr, req_data, iss_valid, iss_rd, rs1_addr, rs2_addr,
    output req_ready, iss_ready, rs1_busy, rs2_busy,
           gpr_wen, gpr_waddr, gpr_wdata, busy_vec
  );
endinterface

// File: rtl/gpr_wb_arbiter.sv
// Round-robin write-back arbiter for the single GPR write port, with a
// per-register busy scoreboard for RAW stall and WAW issue blocking.
module gpr_wb_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int NREQ       = 3
) (
  input logic             clk,
  input logic             rst,
  gpr_wb_arbiter_if.slave bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]         ptr;
  logic [PW-1:0]         gidx;
  logic [PW:0]           cand;
  logic                  found;
  logic [4:0]            gaddr;
  logic [31:0]           busy;
  logic [31:0]           busy_nxt;
  logic                  iss_ok;
  logic                  wen;
  logic [4:0]            waddr;
  logic [DATA_WIDTH-1:0] wdata;

  // Search ptr, ptr+1, ... with wrap; the grant depends only on valid, ptr, rst.
  always_comb begin
    found = 1'b0;
    gidx  = '0;
    cand  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr} + (PW+1)'(k);
      if (cand >= (PW+1)'(NREQ)) cand = cand - (PW+1)'(NREQ);
      if (!found && bus.req_valid[cand[PW-1:0]]) begin
        found = 1'b1;
        gidx  = cand[PW-1:0];
      end
    end
    found = found & rst;
  end

  assign gaddr         = bus.req_addr[5*gidx +: 5];
  assign bus.req_ready = found ? (NREQ'(1) << gidx) : '0;

  assign iss_ok        = rst & ((bus.iss_rd == 5'd0) | ~busy[bus.iss_rd]);
  assign bus.iss_ready = iss_ok;
  assign bus.rs1_busy  = rst & busy[bus.rs1_addr];
  assign bus.rs2_busy  = rst & busy[bus.rs2_addr];
  assign bus.busy_vec  = busy;
  assign bus.gpr_wen   = wen;
  assign bus.gpr_waddr = waddr;
  assign bus.gpr_wdata = wdata;

  // Clear applied before set so a same-cycle set/clear leaves the bit busy.
  always_comb begin
    busy_nxt = busy;
    if (wen) busy_nxt[waddr] = 1'b0;
    if (bus.iss_valid && iss_ok && (bus.iss_rd != 5'd0)) busy_nxt[bus.iss_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr   <= '0;
      busy  <= '0;
      wen   <= 1'b0;
      waddr <= '0;
      wdata <= '0;
    end else begin
      busy <= busy_nxt;
      if (found) begin
        ptr   <= (gidx == PW'(NREQ-1)) ? '0 : gidx + PW'(1);
        waddr <= gaddr;
        wdata <= bus.req_data[DATA_WIDTH*gidx +: DATA_WIDTH];
        wen   <= (gaddr != 5'd0);
      end else begin
        wen <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Self-checking bench for gpr_wb_arbiter: directed vector table followed by
// randomized traffic compared against a behavioural reference model.
module tb_gpr_wb_arbiter;
  localparam int DW   = 64;
  localparam int NREQ = 3;

  logic clk;
  logic rst;

  gpr_wb_arbiter_if #(.DATA_WIDTH(DW), .NREQ(NREQ)) bus ();

  gpr_wb_arbiter #(.DATA_WIDTH(DW), .NREQ(NREQ)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  typedef struct {
    int rst;
    int valid;
    int a0, a1, a2;
    int dat;
    int iv;
    int rd;
    int e_ready;
    int e_iss;
    int e_rs1, e_rs2;
    int e_wen;
    int e_waddr;
    int e_wd;
    int e_busy;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int          m_ptr = 0;
  bit [31:0]   m_busy = '0;
  bit          m_wen = 1'b0;
  bit [4:0]    m_waddr = '0;
  bit [63:0]   m_wdata = '0;
  int          m_gnt = -1;
  bit          m_iss_ok = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic step(input bit tabchk, input vec_t v);
    int        best;
    bit [2:0]  exp_ready;
    bit [31:0] nb;
    @(negedge clk);
    m_gnt = -1;
    best  = NREQ;
    if (rst) begin
      for (int i = 0; i < NREQ; i++) begin
        if (bus.req_valid[i]) begin
          int d;
          d = (i - m_ptr + NREQ) % NREQ;
          if (d < best) begin
            best  = d;
            m_gnt = i;
          end
        end
      end
    end
    exp_ready = '0;
    if (m_gnt >= 0) exp_ready[m_gnt] = 1'b1;
    m_iss_ok = rst && ((bus.iss_rd == 5'd0) || !m_busy[bus.iss_rd]);
    chk("req_ready", 64'(bus.req_ready), 64'(exp_ready));
    chk("iss_ready", 64'(bus.iss_ready), 64'(m_iss_ok));
    chk("rs1_busy",  64'(bus.rs1_busy),  64'(rst && m_busy[bus.rs1_addr]));
    chk("rs2_busy",  64'(bus.rs2_busy),  64'(rst && m_busy[bus.rs2_addr]));
    if (tabchk) begin
      chk("tab_req_ready", 64'(bus.req_ready), 64'(v.e_ready));
      chk("tab_iss_ready", 64'(bus.iss_ready), 64'(v.e_iss));
      chk("tab_rs1_busy",  64'(bus.rs1_busy),  64'(v.e_rs1));
      chk("tab_rs2_busy",  64'(bus.rs2_busy),  64'(v.e_rs2));
    end
    @(posedge clk);
    if (!rst) begin
      m_ptr = 0; m_busy = '0; m_wen = 1'b0; m_waddr = '0; m_wdata = '0;
    end else begin
      nb = m_busy;
      if (m_wen) nb[m_waddr] = 1'b0;
      if (bus.iss_valid && m_iss_ok && (bus.iss_rd != 5'd0)) nb[bus.iss_rd] = 1'b1;
      m_busy = nb;
      if (m_gnt >= 0) begin
        m_waddr = bus.req_addr[5*m_gnt +: 5];
        m_wdata = bus.req_data[DW*m_gnt +: DW];
        m_wen   = (m_waddr != 5'd0);
        m_ptr   = (m_gnt + 1) % NREQ;
      end else begin
        m_wen = 1'b0;
      end
    end
    #1;
    chk("gpr_wen",   64'(bus.gpr_wen),   64'(m_wen));
    chk("gpr_waddr", 64'(bus.gpr_waddr), 64'(m_waddr));
    chk("gpr_wdata", bus.gpr_wdata,      m_wdata);
    chk("busy_vec",  64'(bus.busy_vec),  64'(m_busy));
    if (tabchk) begin
      chk("tab_gpr_wen",   64'(bus.gpr_wen),   64'(v.e_wen));
      chk("tab_gpr_waddr", 64'(bus.gpr_waddr), 64'(v.e_waddr));
      chk("tab_gpr_wdata", bus.gpr_wdata,      64'(v.e_wd));
      chk("tab_busy_vec",  64'(bus.busy_vec),  64'(v.e_busy));
    end
  endtask

  vec_t tab[18];
  vec_t none;

  initial begin
    bit [2:0]  pend;
    bit [4:0]  pa[NREQ];
    bit [63:0] pd[NREQ];

    //        rst vld a0 a1 a2  dat     iv rd  rdy iss rs1 rs2 wen wa  wd       busy
    tab[0]  = '{0, 7, 1, 2, 3, 'h10,   1, 5,  0,  0,  0,  0,  0,  0, 'h0,    'h0};
    tab[1]  = '{0, 7, 1, 2, 3, 'h10,   1, 5,  0,  0,  0,  0,  0,  0, 'h0,    'h0};
    tab[2]  = '{1, 7, 1, 2, 3, 'h20,   0, 0,  1,  1,  0,  0,  1,  1, 'h20,   'h0};
    tab[3]  = '{1, 7, 1, 2, 3, 'h30,   0, 0,  2,  1,  0,  0,  1,  2, 'h31,   'h0};
    tab[4]  = '{1, 7, 1, 2, 3, 'h40,   0, 0,  4,  1,  0,  0,  1,  3, 'h42,   'h0};
    tab[5]  = '{1, 7, 1, 2, 3, 'h50,   0, 0,  1,  1,  0,  0,  1,  1, 'h50,   'h0};
    tab[6]  = '{1, 7, 1, 2, 3, 'h60,   0, 0,  2,  1,  0,  0,  1,  2, 'h61,   'h0};
    tab[7]  = '{1, 7, 1, 2, 3, 'h70,   0, 0,  4,  1,  0,  0,  1,  3, 'h72,   'h0};
    tab[8]  = '{1, 1, 0, 0, 0, 'hFF,   1, 0,  1,  1,  0,  0,  0,  0, 'hFF,   'h0};
    tab[9]  = '{1, 0, 0, 0, 0, 'h1,    1, 5,  0,  1,  0,  0,  0,  0, 'hFF,   'h20};
    tab[10] = '{1, 2, 0, 5, 0, 'hDEAC, 1, 7,  2,  1,  1,  0,  1,  5, 'hDEAD, 'hA0};
    tab[11] = '{1, 0, 0, 0, 0, 'h0,    1, 7,  0,  0,  1,  1,  0,  5, 'hDEAD, 'h80};
    tab[12] = '{1, 4, 0, 0, 7, 'h700,  0, 0,  4,  1,  0,  1,  1,  7, 'h702,  'h80};
    tab[13] = '{1, 1, 9, 0, 0, 'h900,  1, 7,  1,  0,  0,  1,  1,  9, 'h900,  'h0};
    tab[14] = '{1, 0, 0, 0, 0, 'h0,    1, 9,  0,  1,  0,  0,  0,  9, 'h900,  'h200};
    tab[15] = '{1, 2, 0, 4, 0, 'h400,  0, 0,  2,  1,  0,  0,  1,  4, 'h401,  'h200};
    tab[16] = '{0, 7, 1, 2, 3, 'h10,   1, 3,  0,  0,  0,  0,  0,  0, 'h0,    'h0};
    tab[17] = '{1, 6, 1, 2, 3, 'h200,  0, 0,  2,  1,  0,  0,  1,  2, 'h201,  'h0};
    none = tab[0];

    for (int r = 0; r < 18; r++) begin
      rst           = tab[r].rst[0];
      bus.req_valid = 3'(tab[r].valid);
      bus.req_addr  = {5'(tab[r].a2), 5'(tab[r].a1), 5'(tab[r].a0)};
      for (int i = 0; i < NREQ; i++) bus.req_data[DW*i +: DW] = 64'(tab[r].dat) + 64'(i);
      bus.iss_valid = tab[r].iv[0];
      bus.iss_rd    = 5'(tab[r].rd);
      bus.rs1_addr  = 5'd5;
      bus.rs2_addr  = 5'd7;
      step(1'b1, tab[r]);
    end

    // Randomized traffic: requesters hold valid/addr/data until granted.
    pend = '0;
    for (int i = 0; i < NREQ; i++) begin pa[i] = '0; pd[i] = '0; end
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 79) != 0);
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && ($urandom_range(0, 9) < 6)) begin
          pend[i] = 1'b1;
          pa[i]   = 5'($urandom_range(0, 7));
          pd[i]   = {$urandom, $urandom};
        end
        bus.req_addr[5*i +: 5]   = pa[i];
        bus.req_data[DW*i +: DW] = pd[i];
      end
      bus.req_valid = pend;
      bus.iss_valid = 1'($urandom_range(0, 1));
      bus.iss_rd    = 5'($urandom_range(0, 7));
      bus.rs1_addr  = 5'($urandom_range(0, 7));
      bus.rs2_addr  = 5'($urandom_range(0, 7));
      step(1'b0, none);
      if (m_gnt >= 0) pend[m_gnt] = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
